freq_stream_tx: RTL

Transmit end of the frequency-domain streaming interface. It holds one frame of complex spectrum entries, written through a random-access port. On command it emits the frame as a source stream: valid/ready handshake, sop on the first entry, eop on the last. It drives the same sink_* bus that freq_buffer consumes, and also serves as the bench/debug stimulus generator for that buffer.

---
 rtl/freq_stream_pkg.sv | 19 +
 rtl/freq_stream_tx_if.sv | 23 ++
 rtl/freq_stream_tx_skid.sv | 71 +++++++
 rtl/freq_stream_tx.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/freq_stream_pkg.sv
// freq_stream_pkg: shared types for the frequency-domain stream transmitter.
// Optional feature macro used by this block: FREQ_STREAM_TX_REPEAT_EN.
package freq_stream_pkg;

  localparam int CPLX_DATA_WIDTH = 20;

  // Default-width complex entry; modules with another width declare a local twin.
  typedef struct packed {
    logic signed [CPLX_DATA_WIDTH-1:0] re;
    logic signed [CPLX_DATA_WIDTH-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } tx_state_t;

endpackage

// File: rtl/freq_stream_tx_if.sv
// freq_stream_if: source-stream bus (valid/ready, sop/eop, complex data).
interface freq_stream_if
  import freq_stream_pkg::*;
#(
  parameter int DATA_WIDTH = CPLX_DATA_WIDTH
);
  logic                         source_valid;
  logic                         source_ready;
  logic                         source_sop;
  logic                         source_eop;
  logic signed [DATA_WIDTH-1:0] source_re;
  logic signed [DATA_WIDTH-1:0] source_im;

  modport master (
    output source_valid, source_sop, source_eop, source_re, source_im,
    input  source_ready
  );

  modport slave (
    input  source_valid, source_sop, source_eop, source_re, source_im,
    output source_ready
  );
endinterface

// File: rtl/freq_stream_tx_skid.sv
// freq_stream_skid: output register plus one-entry skid buffer. The upstream
// ready is a register, so downstream ready never reaches the memory read path.
module freq_stream_skid
  import freq_stream_pkg::*;
#(
  parameter int DATA_WIDTH = CPLX_DATA_WIDTH
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_in_valid,
  output logic                         o_in_ready,
  input  logic signed [DATA_WIDTH-1:0] i_in_re,
  input  logic signed [DATA_WIDTH-1:0] i_in_im,
  input  logic                         i_in_sop,
  input  logic                         i_in_eop,
  output logic                         o_out_valid,
  input  logic                         i_out_ready,
  output logic signed [DATA_WIDTH-1:0] o_out_re,
  output logic signed [DATA_WIDTH-1:0] o_out_im,
  output logic                         o_out_sop,
  output logic                         o_out_eop
);
  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
    logic                         sop;
    logic                         eop;
  } beat_t;

  beat_t w_in;
  beat_t r_main;
  beat_t r_skid;
  logic  r_main_vld;
  logic  r_skid_vld;

  assign w_in        = {i_in_re, i_in_im, i_in_sop, i_in_eop};
  assign o_in_ready  = ~r_skid_vld;
  assign o_out_valid = r_main_vld;
  assign o_out_re    = r_main.re;
  assign o_out_im    = r_main.im;
  assign o_out_sop   = r_main.sop;
  assign o_out_eop   = r_main.eop;

  // Main/skid register update; the skid only fills when main is stalled.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_main     <= '0;
      r_skid     <= '0;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (r_skid_vld) begin
      if (i_out_ready) begin
        r_main     <= r_skid;
        r_skid_vld <= 1'b0;
      end
    end else if (i_in_valid) begin
      if (!r_main_vld || i_out_ready) begin
        r_main     <= w_in;
        r_main_vld <= 1'b1;
      end else begin
        r_skid     <= w_in;
        r_skid_vld <= 1'b1;
      end
    end else if (r_main_vld && i_out_ready) begin
      // Drained: clear the frame markers so they never show with valid low.
      r_main_vld <= 1'b0;
      r_main.sop <= 1'b0;
      r_main.eop <= 1'b0;
    end
  end
endmodule

// File: rtl/freq_stream_tx.sv
// freq_stream_tx: frame memory with random-access write port, streamed out
// in address order on start. Optional macro FREQ_STREAM_TX_REPEAT_EN adds
// i_repeat for back-to-back frames.
module freq_stream_tx
  import freq_stream_pkg::*;
#(
  parameter  int DATA_WIDTH = 20,
  parameter  int TOT_SIZE   = 1024,
  localparam int ADDR_W     = $clog2(TOT_SIZE)
) (
  input  logic                         i_source_clk,
  input  logic                         i_source_reset_n,
  input  logic                         i_wr_en,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic signed [DATA_WIDTH-1:0] i_wr_re,
  input  logic signed [DATA_WIDTH-1:0] i_wr_im,
  input  logic                         i_start,
`ifdef FREQ_STREAM_TX_REPEAT_EN
  input  logic                         i_repeat,
`endif
  output logic                         o_busy,
  output logic                         o_wr_err,
  freq_stream_if.master                src
);
  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_FETCH  = 2'(FETCH);
  localparam logic [1:0] S_STREAM = 2'(STREAM);

  logic [1:0]                r_state;
  logic [ADDR_W-1:0]         r_rd_ptr;
  logic                      r_rd_done;
  logic                      r_busy;
  logic                      r_wr_err;
  logic [2*DATA_WIDTH-1:0]   r_mem [TOT_SIZE];

  logic [2*DATA_WIDTH-1:0]   w_rd_word;
  logic signed [DATA_WIDTH-1:0] w_rd_re;
  logic signed [DATA_WIDTH-1:0] w_rd_im;
  logic                      w_rd_valid;
  logic                      w_rd_ready;
  logic                      w_rd_fire;
  logic                      w_eop_fire;
  logic                      w_repeat;
  logic                      w_frame_start;

`ifdef FREQ_STREAM_TX_REPEAT_EN
  assign w_repeat = i_repeat;
`else
  assign w_repeat = 1'b0;
`endif

  // The skid's main register acts as the memory read-data register.
  assign w_rd_word     = r_mem[r_rd_ptr];
  assign w_rd_re       = w_rd_word[2*DATA_WIDTH-1:DATA_WIDTH];
  assign w_rd_im       = w_rd_word[DATA_WIDTH-1:0];
  assign w_rd_valid    = ((r_state == S_FETCH) || (r_state == S_STREAM)) && !r_rd_done;
  assign w_rd_fire     = w_rd_valid && w_rd_ready;
  assign w_eop_fire    = src.source_valid && src.source_ready && src.source_eop;
  assign w_frame_start = ((r_state == S_IDLE) && i_start) || (w_eop_fire && w_repeat);

  assign o_busy   = r_busy;
  assign o_wr_err = r_wr_err;

  // Frame memory write port; contents survive reset.
  always_ff @(posedge i_source_clk) begin
    if (i_wr_en && !r_busy) begin
      r_mem[i_wr_addr] <= {i_wr_re, i_wr_im};
    end
  end

  // Flag writes that arrive while a frame is in flight.
  always_ff @(posedge i_source_clk) begin
    if (!i_source_reset_n) begin
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= i_wr_en && r_busy;
    end
  end

  // Read pointer walks 0..TOT_SIZE-1 once per frame without wrapping.
  always_ff @(posedge i_source_clk) begin
    if (!i_source_reset_n) begin
      r_rd_ptr  <= '0;
      r_rd_done <= 1'b0;
    end else if (w_frame_start) begin
      r_rd_ptr  <= '0;
      r_rd_done <= 1'b0;
    end else if (w_rd_fire) begin
      if (r_rd_ptr == ADDR_W'(TOT_SIZE - 1)) begin
        r_rd_done <= 1'b1;
      end else begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
    end
  end

  // Frame sequencing and busy flag.
  always_ff @(posedge i_source_clk) begin
    if (!i_source_reset_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_FETCH;
            r_busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          r_state <= S_STREAM;
        end
        S_STREAM: begin
          if (w_eop_fire) begin
            if (w_repeat) begin
              r_state <= S_FETCH;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  freq_stream_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .i_clk       (i_source_clk),
    .i_rst_n     (i_source_reset_n),
    .i_in_valid  (w_rd_valid),
    .o_in_ready  (w_rd_ready),
    .i_in_re     (w_rd_re),
    .i_in_im     (w_rd_im),
    .i_in_sop    (r_rd_ptr == ADDR_W'(0)),
    .i_in_eop    (r_rd_ptr == ADDR_W'(TOT_SIZE - 1)),
    .o_out_valid (src.source_valid),
    .i_out_ready (src.source_ready),
    .o_out_re    (src.source_re),
    .o_out_im    (src.source_im),
    .o_out_sop   (src.source_sop),
    .o_out_eop   (src.source_eop)
  );
endmodule
